// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester byte arbiter feeding a single UART transmitter with start/ack handshake.
// Define UART_TX_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (req0 first) otherwise.
module uart_tx_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic [7:0] LP_LAST = 8'(ACK_TIMEOUT - 1);
  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] r_tx_data;
  logic [1:0] r_grant;
  logic       w_open;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_accept;
  logic       w_timeout;
  // Reset gates acceptance so ready stays low while reset is held even though the state reads IDLE.
  assign w_open = (r_state == IDLE) && !tx_busy && !reset;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic r_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= 1'b1;
    else if (w_accept) r_last <= w_rdy1;
  assign w_rdy0 = w_open && req0_valid && (!req1_valid || r_last);
  assign w_rdy1 = w_open && req1_valid && (!req0_valid || !r_last);
`else
  assign w_rdy0 = w_open && req0_valid;
  assign w_rdy1 = w_open && req1_valid && !req0_valid;
`endif
  assign w_accept  = w_rdy0 || w_rdy1;
  // Counter holds the number of completed WAIT_ACK cycles, so the pulse lands on the ACK_TIMEOUT-th one.
  assign w_timeout = (r_state == WAIT_ACK) && !tx_busy && (r_cnt == LP_LAST);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_accept ? START : IDLE;
      START:     w_next = WAIT_ACK;
      WAIT_ACK:  w_next = tx_busy ? WAIT_DONE : (w_timeout ? IDLE : WAIT_ACK);
      WAIT_DONE: w_next = tx_busy ? WAIT_DONE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt     <= 8'd0;
      r_tx_data <= 8'h00;
      r_grant   <= 2'b00;
    end else begin
      r_cnt <= (r_state == WAIT_ACK) ? r_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_tx_data <= w_rdy1 ? req1_data : req0_data;
        r_grant   <= {w_rdy1, w_rdy0};
      end else if (w_next == IDLE) begin
        r_grant <= 2'b00;
      end
    end
  assign req0_ready  = w_rdy0;
  assign req1_ready  = w_rdy1;
  assign tx_start    = (r_state == START);
  assign tx_data     = r_tx_data;
  assign grant       = r_grant;
  assign err_timeout = w_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; stimulus queues expected {grant,tx_data} per frame, monitor checks at tx_start.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       err_timeout;
  int n_pass = 0;
  int n_total = 0;
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];

  uart_tx_arbiter #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (req0_ready) rdy0_cnt++;
      if (req1_ready) rdy1_cnt++;
      if (err_timeout) err_cnt++;
      if (req0_ready && req1_ready) begin
        n_total++;
        $display("FAIL both_ready: got 11, want at most one ready");
      end
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_start: got frame %0h, want none", {grant, tx_data});
        end else begin
          e = exp_q.pop_front();
          chk("sb_frame", {22'd0, grant, tx_data}, {22'd0, e});
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tx_start) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic xmit(input int dly, input int len);
    repeat (dly) @(posedge clk);
    #1 tx_busy = 1'b1;
    repeat (len) @(posedge clk);
    #1 tx_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    int n, k, r0, r1, e0;
    fork
      monitor();
    join_none
    req0_valid = 1'b1;
    req0_data  = 8'h41;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", err_timeout, 0);
    req0_valid = 1'b0;
    do_reset();
    // Single request from req0, busy rises two cycles after tx_start and stays for ten.
    r0 = rdy0_cnt;
    req0_valid = 1'b1;
    req0_data  = 8'h41;
    exp_q.push_back({2'b01, 8'h41});
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_start(n);
    chk("t1_start_lat", n, 1);
    repeat (2) @(posedge clk);
    #1 tx_busy = 1'b1;
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_data", tx_data, 8'h41);
    repeat (10) @(posedge clk);
    #1 tx_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_grant_idle", grant, 0);
    chk("t1_ready_pulses", rdy0_cnt - r0, 1);
    // Contention with both requesters valid for four frames.
    do_reset();
    r0 = rdy0_cnt;
    r1 = rdy1_cnt;
    req0_data = 8'hA0;
    req1_data = 8'hB1;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
`else
    repeat (4) exp_q.push_back({2'b01, 8'hA0});
`endif
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(n);
      chk("t2_start_seen", n != 0, 1);
      xmit(2, 3);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    chk("t2_ready0_count", rdy0_cnt - r0, 2);
    chk("t2_ready1_count", rdy1_cnt - r1, 2);
`else
    chk("t2_ready0_count", rdy0_cnt - r0, 4);
    chk("t2_ready1_count", rdy1_cnt - r1, 0);
`endif
    // Ack timeout: tx_busy never rises.
    do_reset();
    e0 = err_cnt;
    req1_valid = 1'b1;
    req1_data  = 8'h5C;
    exp_q.push_back({2'b10, 8'h5C});
    @(negedge clk);
    chk("t3_ready1", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_start(n);
    chk("t3_start_seen", n != 0, 1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        k = i;
        break;
      end
    end
    chk("t3_err_cycle", k, 15);
    @(posedge clk);
    #1;
    chk("t3_grant_clear", grant, 0);
    req0_valid = 1'b1;
    req0_data  = 8'h77;
    exp_q.push_back({2'b01, 8'h77});
    @(negedge clk);
    chk("t3_idle_ready0", req0_ready, 1);
    chk("t3_err_low", err_timeout, 0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_start(n);
    chk("t3_start2_seen", n != 0, 1);
    xmit(1, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_err_once", err_cnt - e0, 1);
    // Busy gate in IDLE, then reset during WAIT_DONE.
    do_reset();
    r1 = rdy1_cnt;
    tx_busy    = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_busy_gate", rdy1_cnt - r1, 0);
    exp_q.push_back({2'b10, 8'h3C});
    tx_busy = 1'b0;
    @(negedge clk);
    chk("t4_ready1", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_start(n);
    chk("t4_start_seen", n != 0, 1);
    repeat (2) @(posedge clk);
    #1 tx_busy = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_grant_done", grant, 2'b10);
    e0 = err_cnt;
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    #1 reset = 1'b1;
    #1;
    chk("t4_rst_tx_start", tx_start, 0);
    chk("t4_rst_tx_data", tx_data, 0);
    chk("t4_rst_grant", grant, 0);
    chk("t4_rst_ready0", req0_ready, 0);
    chk("t4_rst_ready1", req1_ready, 0);
    chk("t4_rst_err", err_timeout, 0);
    @(posedge clk);
    #1 tx_busy = 1'b0;
    @(negedge clk);
    chk("t4_rst_gate_ready0", req0_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back({2'b01, 8'h99});
    @(negedge clk);
    chk("t4_first_clk_ready0", req0_ready, 1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_start(n);
    chk("t4_start2_seen", n != 0, 1);
    xmit(2, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_no_err", err_cnt - e0, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
